// File: rtl/dt_arb_pkg.sv
// Shared constants and types for the digital-tube write arbiter.
package dt_arb_pkg;

    localparam logic [31:0] DT_BASE_ADDR = 32'h0000_7F50;
    localparam int unsigned DT_WIN_WORDS = 2;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  byteen;
        logic [31:0] wdata;
    } dt_req_t;

    // Full 32-bit unsigned compare; the window is [base, base + 4*words - 1].
    function automatic logic dt_in_window(input logic [31:0] a,
                                          input logic [31:0] base,
                                          input int unsigned words);
        logic [31:0] last;
        last = base + 32'(4 * words) - 32'd1;
        return (a >= base) && (a <= last);
    endfunction

endpackage

// File: rtl/dt_req_buf.sv
// One-entry write holding buffer with tube-window check and one-cycle error pulse.
module dt_req_buf
    import dt_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DT_BASE_ADDR,
    parameter int unsigned WIN_WORDS = DT_WIN_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  byteen_i,
    input  logic [31:0] wdata_i,
    input  logic        clear_i,
    output logic        ready_o,
    output logic        full_o,
    output logic [31:0] addr_o,
    output logic [3:0]  byteen_o,
    output logic [31:0] wdata_o,
    output logic        err_o
);

    logic    full_q, full_d;
    logic    err_q, err_d;
    dt_req_t req_q, req_d;
    logic    accept;

    always_comb begin
        full_d = full_q;
        err_d  = 1'b0;
        req_d  = req_q;
        accept = valid_i && !full_q;
        if (clear_i) begin
            full_d = 1'b0;
        end
        // Out-of-window requests are dropped with an error; empty byte enables are dropped quietly.
        if (accept) begin
            if (!dt_in_window(addr_i, BASE_ADDR, WIN_WORDS)) begin
                err_d = 1'b1;
            end else if (byteen_i != 4'd0) begin
                full_d = 1'b1;
                req_d  = '{addr: addr_i, byteen: byteen_i, wdata: wdata_i};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        req_q <= req_d;
    end

    assign ready_o  = !full_q;
    assign full_o   = full_q;
    assign addr_o   = req_q.addr;
    assign byteen_o = req_q.byteen;
    assign wdata_o  = req_q.wdata;
    assign err_o    = err_q;

endmodule

// File: rtl/dt_write_arbiter.sv
// Arbitrates CPU and auxiliary writes into the digital-tube MMIO pair and muxes the read address.
// Define DT_ARB_CPU_PRIO_EN for fixed CPU priority instead of round-robin.
module dt_write_arbiter
    import dt_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DT_BASE_ADDR,
    parameter int unsigned WIN_WORDS = DT_WIN_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_valid,
    input  logic [31:0] r0_addr,
    input  logic [3:0]  r0_byteen,
    input  logic [31:0] r0_wdata,
    output logic        r0_ready,
    input  logic        r1_valid,
    input  logic [31:0] r1_addr,
    input  logic [3:0]  r1_byteen,
    input  logic [31:0] r1_wdata,
    output logic        r1_ready,
    input  logic [31:0] cpu_raddr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rd_stall,
    output logic [31:0] dt_addr,
    output logic [3:0]  dt_byteen,
    output logic [31:0] dt_wdata,
    input  logic [31:0] dt_rd,
    output logic [1:0]  err
);

    logic        full0, full1, clr0, clr1, err0, err1;
    logic [31:0] b0_addr, b1_addr, b0_wdata, b1_wdata;
    logic [3:0]  b0_byteen, b1_byteen;

    logic        gnt_vld, gnt_sel, contest;
    logic [31:0] wr_addr_q, wr_addr_d, dt_wdata_q, dt_wdata_d;
    logic [3:0]  dt_byteen_q, dt_byteen_d;
`ifndef DT_ARB_CPU_PRIO_EN
    logic        last_grant_q, last_grant_d;
`endif

    dt_req_buf #(.BASE_ADDR(BASE_ADDR), .WIN_WORDS(WIN_WORDS)) u_buf0 (
        .clk(clk), .reset(reset), .valid_i(r0_valid), .addr_i(r0_addr),
        .byteen_i(r0_byteen), .wdata_i(r0_wdata), .clear_i(clr0), .ready_o(r0_ready),
        .full_o(full0), .addr_o(b0_addr), .byteen_o(b0_byteen), .wdata_o(b0_wdata),
        .err_o(err0)
    );

    dt_req_buf #(.BASE_ADDR(BASE_ADDR), .WIN_WORDS(WIN_WORDS)) u_buf1 (
        .clk(clk), .reset(reset), .valid_i(r1_valid), .addr_i(r1_addr),
        .byteen_i(r1_byteen), .wdata_i(r1_wdata), .clear_i(clr1), .ready_o(r1_ready),
        .full_o(full1), .addr_o(b1_addr), .byteen_o(b1_byteen), .wdata_o(b1_wdata),
        .err_o(err1)
    );

    always_comb begin
        contest     = full0 && full1;
        gnt_vld     = full0 || full1;
`ifdef DT_ARB_CPU_PRIO_EN
        gnt_sel     = !full0;
`else
        // last_grant tracks the winner of the most recent contest only.
        gnt_sel      = contest ? !last_grant_q : full1;
        last_grant_d = contest ? gnt_sel : last_grant_q;
`endif
        clr0        = gnt_vld && (gnt_sel == REQ_CPU);
        clr1        = gnt_vld && (gnt_sel == REQ_AUX);
        dt_byteen_d = 4'd0;
        wr_addr_d   = wr_addr_q;
        dt_wdata_d  = dt_wdata_q;
        if (clr0) begin
            dt_byteen_d = b0_byteen;
            wr_addr_d   = b0_addr;
            dt_wdata_d  = b0_wdata;
        end else if (clr1) begin
            dt_byteen_d = b1_byteen;
            wr_addr_d   = b1_addr;
            dt_wdata_d  = b1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dt_byteen_q  <= 4'd0;
            wr_addr_q    <= 32'd0;
            dt_wdata_q   <= 32'd0;
`ifndef DT_ARB_CPU_PRIO_EN
            last_grant_q <= REQ_AUX;
`endif
        end else begin
            dt_byteen_q  <= dt_byteen_d;
            wr_addr_q    <= wr_addr_d;
            dt_wdata_q   <= dt_wdata_d;
`ifndef DT_ARB_CPU_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // The tube has one address input: a write pulse owns it and stalls any CPU read.
    assign dt_byteen    = dt_byteen_q;
    assign dt_wdata     = dt_wdata_q;
    assign dt_addr      = (dt_byteen_q != 4'd0) ? wr_addr_q : cpu_raddr;
    assign cpu_rd_stall = (dt_byteen_q != 4'd0);
    assign cpu_rdata    = dt_rd;
    assign err          = {err1, err0};

endmodule

// File: tb/tb_dt_write_arbiter.sv
// Self-checking bench for dt_write_arbiter: vector table, hand sequences and a write scoreboard.
module tb_dt_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic [3:0]  r0_byteen, r1_byteen;
    logic [31:0] cpu_raddr, cpu_rdata, dt_addr, dt_wdata, dt_rd;
    logic        cpu_rd_stall;
    logic [3:0]  dt_byteen;
    logic [1:0]  err;

    dt_write_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_byteen(r0_byteen), .r0_wdata(r0_wdata),
        .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_byteen(r1_byteen), .r1_wdata(r1_wdata),
        .r1_ready(r1_ready),
        .cpu_raddr(cpu_raddr), .cpu_rdata(cpu_rdata), .cpu_rd_stall(cpu_rd_stall),
        .dt_addr(dt_addr), .dt_byteen(dt_byteen), .dt_wdata(dt_wdata), .dt_rd(dt_rd),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          sel;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [1:0]  exp_err;
        bit          exp_pulse;
    } vec_t;

    int   nvec = 0;
    int   nerr = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   src_hist[$];
    bit   log_en = 1'b0;
    int   acc0 = 0;
    int   acc1 = 0;
    vec_t vt[8];

    function automatic bit tb_win(input logic [31:0] a);
        return (a >= 32'h0000_7F50) && (a <= 32'h0000_7F57);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs once per cycle at the falling edge: retire pulses against pending writes, record accepts.
    task automatic sb_step();
        exp_t got;
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (dt_byteen != 4'd0) begin
                got = '{addr: dt_addr, be: dt_byteen, data: dt_wdata};
                nvec++;
                if (q0.size() > 0 && q0[0] == got) begin
                    void'(q0.pop_front());
                    if (log_en) src_hist.push_back(0);
                end else if (q1.size() > 0 && q1[0] == got) begin
                    void'(q1.pop_front());
                    if (log_en) src_hist.push_back(1);
                end else begin
                    nerr++;
                    $display("FAIL sb_pulse: got addr %h be %h data %h, no pending write matches",
                             dt_addr, dt_byteen, dt_wdata);
                end
            end
            if (r0_valid && r0_ready && tb_win(r0_addr) && r0_byteen != 4'd0) begin
                q0.push_back('{addr: r0_addr, be: r0_byteen, data: r0_wdata});
                if (log_en) acc0++;
            end
            if (r1_valid && r1_ready && tb_win(r1_addr) && r1_byteen != 4'd0) begin
                q1.push_back('{addr: r1_addr, be: r1_byteen, data: r1_wdata});
                if (log_en) acc1++;
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        sb_step();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d);
        if (sel) begin
            r1_valid = 1'b1; r1_addr = a; r1_byteen = be; r1_wdata = d;
        end else begin
            r0_valid = 1'b1; r0_addr = a; r0_byteen = be; r0_wdata = d;
        end
    endtask

    task automatic idle();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        repeat (2) begin half(); nxt(); end
        reset = 1'b0;
    endtask

    task automatic pair(input string tag, input logic [31:0] first, input logic [31:0] second);
        half(); nxt();
        idle();
        half();
        check({tag, " r0_ready busy"}, 32'(r0_ready), 32'd0);
        check({tag, " r1_ready busy"}, 32'(r1_ready), 32'd0);
        nxt(); half();
        check({tag, " first data"}, dt_wdata, first);
        nxt(); half();
        check({tag, " second data"}, dt_wdata, second);
        check({tag, " b2b byteen"}, 32'(dt_byteen), 32'hF);
        nxt(); half();
        check({tag, " pulse end"}, 32'(dt_byteen), 32'd0);
        nxt();
    endtask

    initial begin
        logic [31:0] exp_first, exp_second;
        int          viol;

        reset = 1'b1;
        r0_valid = 1'b0; r0_addr = '0; r0_byteen = '0; r0_wdata = '0;
        r1_valid = 1'b0; r1_addr = '0; r1_byteen = '0; r1_wdata = '0;
        cpu_raddr = 32'h1234_0000;
        dt_rd = 32'h0BAD_F00D;

        vt[0] = '{1'b0, 32'h0000_7F50, 4'hF, 32'h1234_5678, 2'b00, 1'b1};
        vt[1] = '{1'b0, 32'h0000_7F54, 4'h3, 32'h0000_BEEF, 2'b00, 1'b1};
        vt[2] = '{1'b1, 32'h0000_7F58, 4'hF, 32'h1111_1111, 2'b10, 1'b0};
        vt[3] = '{1'b0, 32'h0000_7F50, 4'h0, 32'h2222_2222, 2'b00, 1'b0};
        vt[4] = '{1'b0, 32'h0000_7F4F, 4'hF, 32'h3333_3333, 2'b01, 1'b0};
        vt[5] = '{1'b1, 32'h0000_7F57, 4'h8, 32'h4444_4444, 2'b00, 1'b1};
        vt[6] = '{1'b1, 32'hFFFF_7F50, 4'hF, 32'h5555_5555, 2'b10, 1'b0};
        vt[7] = '{1'b1, 32'h0000_7F50, 4'h1, 32'h6666_6666, 2'b00, 1'b1};

        nxt(); nxt(); nxt();
        reset = 1'b0;
        half();
        check("rst r0_ready", 32'(r0_ready), 32'd1);
        check("rst r1_ready", 32'(r1_ready), 32'd1);
        check("rst dt_byteen", 32'(dt_byteen), 32'd0);
        check("rst dt_wdata", dt_wdata, 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst stall", 32'(cpu_rd_stall), 32'd0);
        check("rst dt_addr", dt_addr, 32'h1234_0000);
        nxt();

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].sel, vt[i].addr, vt[i].be, vt[i].data);
            half();
            check($sformatf("v%0d ready c0", i), 32'(vt[i].sel ? r1_ready : r0_ready), 32'd1);
            nxt();
            idle();
            half();
            check($sformatf("v%0d err c1", i), 32'(err), 32'(vt[i].exp_err));
            check($sformatf("v%0d ready c1", i), 32'(vt[i].sel ? r1_ready : r0_ready),
                  32'(!vt[i].exp_pulse));
            check($sformatf("v%0d no early pulse", i), 32'(dt_byteen), 32'd0);
            nxt(); half();
            check($sformatf("v%0d pulse c2", i), 32'(dt_byteen != 4'd0), 32'(vt[i].exp_pulse));
            check($sformatf("v%0d err c2", i), 32'(err), 32'd0);
            check($sformatf("v%0d ready c2", i), 32'(vt[i].sel ? r1_ready : r0_ready), 32'd1);
            if (vt[i].exp_pulse) begin
                check($sformatf("v%0d dt_addr", i), dt_addr, vt[i].addr);
                check($sformatf("v%0d dt_byteen", i), 32'(dt_byteen), 32'(vt[i].be));
                check($sformatf("v%0d dt_wdata", i), dt_wdata, vt[i].data);
                check($sformatf("v%0d stall", i), 32'(cpu_rd_stall), 32'd1);
            end
            nxt(); half();
            check($sformatf("v%0d pulse c3", i), 32'(dt_byteen), 32'd0);
            nxt();
        end

        // Simultaneous requests: first contest goes to r0, the repeat follows the arbitration mode.
        do_reset();
        drive(1'b0, 32'h0000_7F50, 4'hF, 32'hAAAA_0001);
        drive(1'b1, 32'h0000_7F54, 4'hF, 32'hBBBB_0002);
        pair("sim1", 32'hAAAA_0001, 32'hBBBB_0002);
        drive(1'b0, 32'h0000_7F50, 4'hF, 32'hCCCC_0003);
        drive(1'b1, 32'h0000_7F54, 4'hF, 32'hDDDD_0004);
`ifdef DT_ARB_CPU_PRIO_EN
        exp_first = 32'hCCCC_0003; exp_second = 32'hDDDD_0004;
`else
        exp_first = 32'hDDDD_0004; exp_second = 32'hCCCC_0003;
`endif
        pair("sim2", exp_first, exp_second);

        // Read collision with an issuing write.
        cpu_raddr = 32'h0000_7F54;
        dt_rd = 32'hCAFE_0001;
        drive(1'b0, 32'h0000_7F50, 4'hF, 32'h0000_55AA);
        half(); nxt();
        idle();
        half(); nxt(); half();
        check("rd stall", 32'(cpu_rd_stall), 32'd1);
        check("rd dt_addr wr", dt_addr, 32'h0000_7F50);
        check("rd rdata c0", cpu_rdata, 32'hCAFE_0001);
        nxt();
        dt_rd = 32'h1357_9BDF;
        half();
        check("rd no stall", 32'(cpu_rd_stall), 32'd0);
        check("rd dt_addr rd", dt_addr, 32'h0000_7F54);
        check("rd rdata c1", cpu_rdata, 32'h1357_9BDF);
        nxt();

        // Reset with both buffers full discards the pending writes.
        drive(1'b0, 32'h0000_7F50, 4'hF, 32'hE1E1_E1E1);
        drive(1'b1, 32'h0000_7F54, 4'hF, 32'hE2E2_E2E2);
        half(); nxt();
        idle();
        reset = 1'b1;
        half();
        check("mid r0 full", 32'(r0_ready), 32'd0);
        check("mid r1 full", 32'(r1_ready), 32'd0);
        nxt();
        reset = 1'b0;
        half();
        check("mid dt_byteen", 32'(dt_byteen), 32'd0);
        check("mid r0_ready", 32'(r0_ready), 32'd1);
        check("mid r1_ready", 32'(r1_ready), 32'd1);
        nxt(); half();
        check("mid no pulse", 32'(dt_byteen), 32'd0);
        nxt();

        // Sustained contention: both requesters hold valid for 20 cycles.
        log_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 32'h0000_7F50, 4'hF, 32'hA000_0000 | 32'(acc0));
            drive(1'b1, 32'h0000_7F54, 4'hF, 32'hB000_0000 | 32'(acc1));
            half(); nxt();
        end
        idle();
        repeat (4) begin half(); nxt(); end
        log_en = 1'b0;
        check("sus q0 drained", 32'(q0.size()), 32'd0);
        check("sus q1 drained", 32'(q1.size()), 32'd0);
        check("sus issue count", 32'(src_hist.size()), 32'(acc0 + acc1));
        check("sus r0 >= 5", 32'(acc0 >= 5), 32'd1);
        check("sus r1 >= 5", 32'(acc1 >= 5), 32'd1);
        viol = 0;
        for (int k = 1; k < src_hist.size(); k++) begin
            if (src_hist[k] == src_hist[k-1]) viol++;
        end
        check("sus alternation", 32'(viol), 32'd0);

        check("end q0 empty", 32'(q0.size()), 32'd0);
        check("end q1 empty", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
